reg_file_clr: RTL and testbench
===============================

Name: reg_file_clr

Overview:
- 32x32 integer register file feeding the ALU operand inputs: rd1_o drives A_in; rd2_o drives the B-side mux alongside the I-type immediate.
- Two combinational read ports and one synchronous write port (write-back from ALU result). x0 is hardwired to zero.
- Built-in clear sequencer zeroes every register after reset or on request.
- busy_o holds the core off during the clear sequence.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width
- DEPTH, 32, number of registers (2**ADDR_W)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- we_in  input  1  write enable from the control unit
- rd_addr_in  input  ADDR_W  destination register address
- wd_in  input  DATA_W  write-back data (ALU result_o)
- rs1_addr_in  input  ADDR_W  read port 1 address
- rs2_addr_in  input  ADDR_W  read port 2 address
- rd1_o  output  DATA_W  read data 1 (to ALU A_in)
- rd2_o  output  DATA_W  read data 2 (to ALU B operand mux)
- clr_req_in  input  1  single-cycle request to re-run the clear sequence
- busy_o  output  1  high while the clear sequence runs; core must stall

Behaviour:
- Reset:
  - Synchronous, active-high. Sampled on the rising edge of clk.
  - rst=1 at an edge: state <= CLEAR, clr_cnt <= 0. Array contents are not touched on the reset edge itself.
  - Output values while in CLEAR: busy_o=1, rd1_o=0, rd2_o=0.
- States:
  - CLEAR: each edge with rst=0 writes 0 to reg[clr_cnt], then clr_cnt <= clr_cnt+1.
  - CLEAR exit: when clr_cnt==DEPTH-1, that edge clears the last entry and moves to RUN.
  - Clear duration: exactly DEPTH (32) non-reset edges. busy_o falls after the 32nd.
  - RUN: normal operation, busy_o=0. clr_req_in=1 at an edge moves to CLEAR with clr_cnt <= 0.
- busy_o is decoded from registered state only. It never depends combinationally on inputs.
- Reads:
  - Purely combinational: rdN_o = reg[rsN_addr_in].
  - Address 0 always returns 0.
  - Forced to 0 while in CLEAR.
  - No write-to-read bypass: a same-cycle write is visible only after the edge. This avoids a combinational loop through the ALU in the single-cycle datapath.
- Writes:
  - In RUN, on the rising edge, if we_in=1 and rd_addr_in!=0: reg[rd_addr_in] <= wd_in.
  - A write to x0 is discarded.
- Writes during CLEAR: we_in is ignored for the whole sequence, including the final clear edge.
- Simultaneous events, in priority order:
  - rst above everything; reset mid-CLEAR restarts clr_cnt at 0.
  - clr_req_in and we_in on the same RUN edge: the clear wins and the write is dropped.
  - clr_req_in while already in CLEAR: ignored; the count is not restarted.
- Both read ports may address the same register. Both return the same value.
- clr_cnt is ADDR_W bits wide and never wraps past DEPTH-1. The state change happens on the DEPTH-1 edge.

Test Plan:
- Reset then idle: assert rst 1 cycle, release -> busy_o=1 for exactly 32 edges, then 0. rd1_o/rd2_o read 0 for addresses 0..31.
- Write/read in RUN: we_in=1, rd_addr_in=5, wd_in=32'hDEADBEEF -> same cycle rs1_addr_in=5 still shows 0. After the edge, rd1_o=32'hDEADBEEF. rs2_addr_in=5 gives the same value on rd2_o.
- x0 protection: write 32'hFFFFFFFF to address 0 -> rd1_o with rs1_addr_in=0 stays 32'h00000000.
- Write during CLEAR: we_in=1, addr 7, data 32'h12345678 at clear cycle 10 -> after busy_o falls, reg 7 reads 0.
- clr_req_in after loading regs 1..31 with their index -> busy_o high 32 cycles; all reads 0 afterward. A write asserted with clr_req_in on the same edge is lost.
- Reset mid-clear: rst at clear cycle 20 -> busy_o stays high a further 32 edges after rst is released, then falls.

Source files
------------

// File: rtl/reg_file_clr.sv
// 32x32 integer register file: two combinational read ports, one write port, x0 tied to zero.
// A built-in sequencer zeroes every entry after reset or on request, stalling the core via busy_o.
module reg_file_clr #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic [DATA_W-1:0] wd_in,
  input  logic [ADDR_W-1:0] rs1_addr_in,
  input  logic [ADDR_W-1:0] rs2_addr_in,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              clr_req_in,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_d;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_in_clear;
  logic w_wr_en;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StClear;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_clr_cnt <= w_clr_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d   = r_state;
    w_clr_cnt_d = r_clr_cnt;
    unique case (r_state)
      StClear: begin
        if (r_clr_cnt == LastIdx) begin
          w_state_d   = StRun;
          w_clr_cnt_d = '0;
        end else begin
          w_clr_cnt_d = r_clr_cnt + 1'b1;
        end
      end
      StRun: begin
        if (clr_req_in) begin
          w_state_d   = StClear;
          w_clr_cnt_d = '0;
        end
      end
      default: begin
        w_state_d   = StClear;
        w_clr_cnt_d = '0;
      end
    endcase
  end

  // Output decode: registered state only
  always_comb begin
    w_in_clear = 1'b0;
    unique case (r_state)
      StClear: w_in_clear = 1'b1;
      StRun:   w_in_clear = 1'b0;
      default: w_in_clear = 1'b1;
    endcase
  end

  assign busy_o = w_in_clear;

  // A clear request on the same edge as a write drops the write.
  assign w_wr_en = (r_state == StRun) && !clr_req_in && we_in && (rd_addr_in != '0);

  // The reset edge leaves the array untouched; the sequence zeroes it afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_in_clear) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr_en) begin
        r_mem[rd_addr_in] <= wd_in;
      end
    end
  end

  // No write bypass: keeps the ALU result path free of a combinational loop.
  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (!w_in_clear) begin
      if (rs1_addr_in != '0) rd1_o = r_mem[rs1_addr_in];
      if (rs2_addr_in != '0) rd2_o = r_mem[rs2_addr_in];
    end
  end

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed testbench for reg_file_clr: clear sequencing, read/write behaviour and
// priority between reset, clear requests and writes.
module tb_reg_file_clr;

  logic        clk;
  logic        rst;
  logic        we_in;
  logic [4:0]  rd_addr_in;
  logic [31:0] wd_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;
  logic [31:0] rd1_o;
  logic [31:0] rd2_o;
  logic        clr_req_in;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_clr #(
    .DATA_W(32),
    .ADDR_W(5),
    .DEPTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .we_in      (we_in),
    .rd_addr_in (rd_addr_in),
    .wd_in      (wd_in),
    .rs1_addr_in(rs1_addr_in),
    .rs2_addr_in(rs2_addr_in),
    .rd1_o      (rd1_o),
    .rd2_o      (rd2_o),
    .clr_req_in (clr_req_in),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy_o drops, bounded at 40.
  task automatic wait_clear(output int n);
    n = 0;
    while (busy_o && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 1", busy_o);
    end
    rs1_addr_in = 5'd3;
    rs2_addr_in = 5'd17;
    #1;
    n_cmp++;
    if (rd1_o !== 32'h0 || rd2_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_reads_forced: got %h/%h want 0/0", rd1_o, rd2_o);
    end
    wait_clear(n);
    n_cmp++;
    if (n !== 32) begin
      n_err++;
      $display("FAIL reset_clear_len: got %0d edges want 32", n);
    end
    for (int a = 0; a < 32; a++) begin
      rs1_addr_in = 5'(a);
      rs2_addr_in = 5'(31 - a);
      #1;
      n_cmp++;
      if (rd1_o !== 32'h0 || rd2_o !== 32'h0) begin
        n_err++;
        $display("FAIL reset_zero[%0d]: got %h/%h want 0/0", a, rd1_o, rd2_o);
      end
    end
  endtask

  task automatic test_write_read();
    we_in       = 1'b1;
    rd_addr_in  = 5'd5;
    wd_in       = 32'hDEADBEEF;
    rs1_addr_in = 5'd5;
    rs2_addr_in = 5'd5;
    #1;
    n_cmp++;
    if (rd1_o !== 32'h0) begin
      n_err++;
      $display("FAIL no_bypass: got %h want 00000000", rd1_o);
    end
    tick();
    we_in = 1'b0;
    n_cmp++;
    if (rd1_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_rd1: got %h want deadbeef", rd1_o);
    end
    n_cmp++;
    if (rd2_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_rd2: got %h want deadbeef", rd2_o);
    end
  endtask

  task automatic test_x0();
    we_in       = 1'b1;
    rd_addr_in  = 5'd0;
    wd_in       = 32'hFFFFFFFF;
    tick();
    we_in       = 1'b0;
    rs1_addr_in = 5'd0;
    rs2_addr_in = 5'd5;
    #1;
    n_cmp++;
    if (rd1_o !== 32'h0) begin
      n_err++;
      $display("FAIL x0_zero: got %h want 00000000", rd1_o);
    end
    n_cmp++;
    if (rd2_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL x0_other_intact: got %h want deadbeef", rd2_o);
    end
  endtask

  task automatic test_write_during_clear();
    int n;
    clr_req_in = 1'b1;
    tick();
    clr_req_in = 1'b0;
    repeat (10) tick();
    // Held through the final clear edge; must be ignored throughout.
    we_in      = 1'b1;
    rd_addr_in = 5'd7;
    wd_in      = 32'h12345678;
    wait_clear(n);
    we_in = 1'b0;
    n_cmp++;
    if (n !== 22) begin
      n_err++;
      $display("FAIL clr_write_len: got %0d edges want 22", n);
    end
    rs1_addr_in = 5'd7;
    rs2_addr_in = 5'd5;
    #1;
    n_cmp++;
    if (rd1_o !== 32'h0) begin
      n_err++;
      $display("FAIL clr_write_ignored: got %h want 00000000", rd1_o);
    end
    n_cmp++;
    if (rd2_o !== 32'h0) begin
      n_err++;
      $display("FAIL clr_wiped_r5: got %h want 00000000", rd2_o);
    end
  endtask

  task automatic test_clr_req();
    int n;
    for (int a = 1; a < 32; a++) begin
      we_in      = 1'b1;
      rd_addr_in = 5'(a);
      wd_in      = 32'(a);
      tick();
    end
    we_in       = 1'b0;
    rs1_addr_in = 5'd3;
    rs2_addr_in = 5'd31;
    #1;
    n_cmp++;
    if (rd1_o !== 32'd3 || rd2_o !== 32'd31) begin
      n_err++;
      $display("FAIL load_readback: got %h/%h want 3/1f", rd1_o, rd2_o);
    end
    clr_req_in = 1'b1;
    we_in      = 1'b1;
    rd_addr_in = 5'd9;
    wd_in      = 32'hAAAA5555;
    tick();
    clr_req_in = 1'b0;
    we_in      = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL clr_req_busy: got %b want 1", busy_o);
    end
    repeat (15) tick();
    // A second request mid-sequence must not restart the count.
    clr_req_in = 1'b1;
    tick();
    clr_req_in = 1'b0;
    wait_clear(n);
    n_cmp++;
    if (n !== 16) begin
      n_err++;
      $display("FAIL clr_req_len: got %0d remaining edges want 16", n);
    end
    for (int a = 0; a < 32; a++) begin
      rs1_addr_in = 5'(a);
      rs2_addr_in = 5'(a);
      #1;
      n_cmp++;
      if (rd1_o !== 32'h0 || rd2_o !== 32'h0) begin
        n_err++;
        $display("FAIL clr_req_zero[%0d]: got %h/%h want 0/0", a, rd1_o, rd2_o);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clr_req_in = 1'b1;
    tick();
    clr_req_in = 1'b0;
    repeat (20) tick();
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_clear_busy: got %b want 1", busy_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear(n);
    n_cmp++;
    if (n !== 32) begin
      n_err++;
      $display("FAIL reset_mid_clear_len: got %0d edges want 32", n);
    end
    // Run-mode write after the restart completes still works.
    we_in       = 1'b1;
    rd_addr_in  = 5'd12;
    wd_in       = 32'h0BADF00D;
    tick();
    we_in       = 1'b0;
    rs1_addr_in = 5'd12;
    #1;
    n_cmp++;
    if (rd1_o !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL post_restart_write: got %h want 0badf00d", rd1_o);
    end
  endtask

  initial begin
    rst         = 1'b0;
    we_in       = 1'b0;
    rd_addr_in  = '0;
    wd_in       = '0;
    rs1_addr_in = '0;
    rs2_addr_in = '0;
    clr_req_in  = 1'b0;
    test_reset();
    test_write_read();
    test_x0();
    test_write_during_clear();
    test_clr_req();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
